// File: rtl/bit_serializer.sv
// bit_serializer
// Parallel-to-serial front end for the serial sequence detector. Words arrive
// over a valid/ready handshake and leave one bit per clock on x. A one-deep
// holding register lets frames run back-to-back. An optional idle gap of GAP
// cycles can be inserted after every word.
//
// Parameters:
//   WIDTH     word width (>= 2)
//   GAP       idle cycles after each word (0..15)
//   IDLE_BIT  level on x when no payload bit is active
//   MSB_FIRST 1 = shift MSB first, 0 = LSB first
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   clr        synchronous active-high reset
//   din        parallel word, sampled only when accepted
//   din_valid  din carries a word
//   din_ready  a word can be taken (holding register empty)
//   x          serial bit
//   x_valid    x carries a payload bit
//   sof        first bit of a word
//   eof        last bit of a word
//   busy       shifting, in a gap, or holding a word
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = 1'b1,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit              GAP_EN   = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_GAP   = 2'b10
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [CW-1:0]    bitcnt, bitcnt_n;
    logic [3:0]       gapcnt, gapcnt_n;
    logic             accept;
    logic             load_pt;
    logic             next_bit;

    // din_ready mirrors !hold_full, so accepting never overwrites a held word.
    assign accept = din_valid && !hold_full;

    // A load point is an edge where shreg may take a new word. The >=
    // comparisons keep a corrupted counter from running past its limit.
    always_comb begin
        load_pt = 1'b0;
        case (state)
            S_IDLE:  load_pt = 1'b1;
            S_SHIFT: load_pt = (bitcnt >= BIT_LAST) && !GAP_EN;
            S_GAP:   load_pt = (gapcnt >= GAP_LAST);
            default: load_pt = 1'b0;
        endcase
    end

    // Next-state logic. A held word always wins over a new one at a load
    // point; a new word accepted at a load point bypasses hold entirely.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        bitcnt_n    = bitcnt;
        gapcnt_n    = gapcnt;
        if (load_pt) begin
            if (hold_full) begin
                shreg_n     = hold;
                hold_full_n = 1'b0;
                state_n     = S_SHIFT;
                bitcnt_n    = '0;
            end else if (accept) begin
                shreg_n  = din;
                state_n  = S_SHIFT;
                bitcnt_n = '0;
            end else begin
                state_n = S_IDLE;
            end
        end else begin
            if (accept) begin
                hold_n      = din;
                hold_full_n = 1'b1;
            end
            case (state)
                S_SHIFT: begin
                    if (bitcnt >= BIT_LAST) begin
                        state_n  = S_GAP;
                        gapcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + CW'(1);
                    end
                end
                S_GAP:   gapcnt_n = gapcnt + 4'd1;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Bit presented in the coming cycle, taken from the next-cycle word and
    // counter so that x can be a plain register.
    always_comb begin
        if (MSB_FIRST)
            next_bit = shreg_n[BIT_LAST - bitcnt_n];
        else
            next_bit = shreg_n[bitcnt_n];
    end

    // All state and every output are registered here. Outputs are decoded
    // from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            bitcnt    <= '0;
            gapcnt    <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            bitcnt    <= bitcnt_n;
            gapcnt    <= gapcnt_n;
            x         <= (state_n == S_SHIFT) ? next_bit : IDLE_BIT;
            x_valid   <= (state_n == S_SHIFT);
            sof       <= (state_n == S_SHIFT) && (bitcnt_n == '0);
            eof       <= (state_n == S_SHIFT) && (bitcnt_n == BIT_LAST);
            busy      <= (state_n != S_IDLE) || hold_full_n;
            din_ready <= !hold_full_n;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
// Drives three bit_serializer instances from one shared stimulus stream:
//   inst0: defaults (MSB first, no gap, idle level 1)
//   inst1: GAP = 2
//   inst2: LSB first, no gap, idle level 0
// Each instance is checked every cycle against a word-level reference model
// that only tracks when each accepted word starts transmitting.
module tb_bit_serializer;

    localparam int W    = 8;
    localparam int NONE = -1000;

    logic         clk = 1'b0;
    logic         clr;
    logic         din_valid;
    logic [W-1:0] din;
    wire  [2:0]   rdy, xo, xv, so, eo, bz;

    int           ls [3];
    int           ps [3];
    logic [W-1:0] ld [3];
    logic [W-1:0] pd [3];
    int           cyc;
    int           nChecks;
    int           nFails;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
        .x(xo[0]), .x_valid(xv[0]), .sof(so[0]), .eof(eo[0]), .busy(bz[0])
    );

    bit_serializer #(.WIDTH(W), .GAP(2), .IDLE_BIT(1'b1), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
        .x(xo[1]), .x_valid(xv[1]), .sof(so[1]), .eof(eo[1]), .busy(bz[1])
    );

    bit_serializer #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) u2 (
        .clk(clk), .clr(clr), .din(din), .din_valid(din_valid), .din_ready(rdy[2]),
        .x(xo[2]), .x_valid(xv[2]), .sof(so[2]), .eof(eo[2]), .busy(bz[2])
    );

    function automatic int gapOf(int i);
        return (i == 1) ? 2 : 0;
    endfunction

    function automatic logic msbOf(int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic idleOf(int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    // Expected {x, x_valid, sof, eof, busy, din_ready} of instance i in the
    // cycle following edge t. A word occupies cycles start..start+W-1; the
    // block stays busy through the trailing gap; hold is full while the most
    // recent word has been accepted but not yet started.
    function automatic logic [5:0] expOut(int i, int t);
        logic         xb;
        logic         v;
        logic         s;
        logic         e;
        logic         b;
        logic         r;
        int           k;
        int           st;
        logic [W-1:0] wd;
        xb = idleOf(i);
        v  = 1'b0;
        s  = 1'b0;
        e  = 1'b0;
        st = NONE;
        wd = '0;
        if (t >= ls[i] && t <= ls[i] + W - 1) begin
            st = ls[i];
            wd = ld[i];
        end else if (t >= ps[i] && t <= ps[i] + W - 1) begin
            st = ps[i];
            wd = pd[i];
        end
        if (st != NONE) begin
            k  = t - st;
            xb = msbOf(i) ? wd[W-1-k] : wd[k];
            v  = 1'b1;
            s  = (k == 0);
            e  = (k == W - 1);
        end
        b = (t <= ls[i] + W + gapOf(i) - 1);
        r = !(ls[i] > t);
        return {xb, v, s, e, b, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s cycle %0d: {x,x_valid,sof,eof,busy,din_ready} got %b expected %b",
                     tag, cyc, observed, expected);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare
    // every instance a little after the edge.
    task automatic applyStimulus(input logic c, input logic v, input logic [W-1:0] d);
        int s;
        clr       = c;
        din_valid = v;
        din       = d;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                ls[i] = NONE;
                ps[i] = NONE;
            end else if (v && ls[i] <= cyc - 1) begin
                s = ls[i] + W + gapOf(i);
                if (s < cyc) s = cyc;
                ps[i] = ls[i];
                pd[i] = ld[i];
                ls[i] = s;
                ld[i] = d;
            end
        end
        #1;
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("inst%0d", i), {xo[i], xv[i], so[i], eo[i], bz[i], rdy[i]}, expOut(i, cyc));
    endtask

    task automatic idleCycles(input int n);
        for (int j = 0; j < n; j++) applyStimulus(1'b0, 1'b0, '0);
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        cyc     = 0;
        for (int i = 0; i < 3; i++) begin
            ls[i] = NONE;
            ps[i] = NONE;
            ld[i] = '0;
            pd[i] = '0;
        end

        $display("[TB] reset with din_valid high");
        applyStimulus(1'b1, 1'b1, 8'hA5);
        applyStimulus(1'b1, 1'b1, 8'hA5);
        idleCycles(2);

        $display("[TB] single word A5");
        applyStimulus(1'b0, 1'b1, 8'hA5);
        idleCycles(10);

        $display("[TB] back-to-back F0 then 0F");
        applyStimulus(1'b0, 1'b1, 8'hF0);
        applyStimulus(1'b0, 1'b1, 8'h0F);
        idleCycles(20);

        $display("[TB] queued FF then 00");
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'h00);
        idleCycles(25);

        $display("[TB] single bits 01 and 80");
        applyStimulus(1'b0, 1'b1, 8'h01);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 8'h80);
        idleCycles(10);

        $display("[TB] reset mid-word with a held word");
        applyStimulus(1'b0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 1'b1, 8'h3C);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 8'h81);
        idleCycles(10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++)
            applyStimulus(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), W'($urandom));
        idleCycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `x`. It holds one pending word, so frames run back-to-back with no bubble, and it can insert a programmable idle gap between words. `x` connects directly to the detector's serial input `x`. `x_valid` tells the consumer which cycles carry payload.

## Interface
- `WIDTH`, 8: word width, ≥2.
- `GAP`, 0: idle cycles inserted after each word, 0..15.
- `IDLE_BIT`, 1'b1: level driven on `x` when no payload bit is active.
- `MSB_FIRST`, 1: 1 = shift MSB first, 0 = shift LSB first.
- `clk`  in  1  clock; all state changes on posedge.
- `clr`  in  1  reset; synchronous, active-high. Port name `clr` is retained.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can take a word; equals !hold_full.
- `x`  out  1  serial bit.
- `x_valid`  out  1  `x` carries a payload bit.
- `sof`  out  1  high with the first bit of each word.
- `eof`  out  1  high with the last bit of each word.
- `busy`  out  1  state != IDLE or hold_full.

## Operation
- Storage:
  - `shreg`: active word.
  - `hold`: 1-deep pending word, with a `hold_full` flag.
  - `bitcnt`: 0..WIDTH-1.
  - `gapcnt`: 0..GAP-1.
- Accept = `din_valid` && `din_ready`. `din` is sampled only on accept.
- FSM states: IDLE, SHIFT, GAP.
- Load point: a clock edge at which one of these holds:
  - state is IDLE;
  - state is SHIFT with `bitcnt` == WIDTH-1 and GAP == 0;
  - state is GAP with `gapcnt` == GAP-1.
- At a load point, first matching rule applies:
  - `hold_full`: `shreg` <= `hold`; `hold_full` <= 0; go to SHIFT; `bitcnt` <= 0.
  - Accept: `shreg` <= `din`; go to SHIFT; `bitcnt` <= 0. The word bypasses `hold`.
  - Otherwise: go to IDLE.
- At the edge where state is SHIFT and `bitcnt` == WIDTH-1 with GAP > 0: go to GAP; `gapcnt` <= 0.
- Accept at an edge that is not a load point: `hold` <= `din`; `hold_full` <= 1. This cannot collide with a full hold, because `din_ready` = 0 then.
- SHIFT outputs:
  - `x` = `shreg`[WIDTH-1-`bitcnt`] when MSB_FIRST = 1, else `shreg`[`bitcnt`].
  - `x_valid` = 1.
  - `sof` = (`bitcnt` == 0); `eof` = (`bitcnt` == WIDTH-1).
  - `bitcnt` increments every cycle.
- IDLE and GAP outputs: `x` = IDLE_BIT; `x_valid` = `sof` = `eof` = 0.
- All outputs come only from registers, with no combinational path from `din` or `din_valid`.
- `bitcnt` and `gapcnt` never wrap past their limits. Any unreachable state encoding recovers to IDLE on the next edge.

## Timing
- Reset, on any edge with `clr` = 1:
  - state IDLE, `hold_full` 0, counters 0;
  - cycle after: `x` = IDLE_BIT, `x_valid` = `sof` = `eof` = `busy` = 0, `din_ready` = 1.
  - `clr` overrides a simultaneous accept; the word is dropped.
- Reset mid-word: remaining bits and any held word are discarded. The next cycle is clean IDLE with no `eof` emitted.
- Latency: a word accepted in IDLE at edge k drives its first bit (`sof` = 1) in the cycle after edge k. The last bit (`eof`) follows WIDTH-1 cycles later.
- Throughput with GAP = 0: one word per WIDTH cycles. The bit after `eof` is the next word's `sof` whenever a word is held, or is accepted at the last-bit edge.
- Throughput with GAP = G: exactly G cycles of `x_valid` = 0 between `eof` and the next `sof`.
- `din_ready` falls the cycle after a word enters `hold`. It rises the cycle after `hold` drains into `shreg`.

## Test plan
- Reset: `clr` = 1 for 2 cycles while `din_valid` = 1 -> no word taken; afterwards `x` = 1, `x_valid` = 0, `din_ready` = 1, `busy` = 0.
- Single word, WIDTH 8, MSB_FIRST 1, GAP 0: accept 8'hA5 at edge k -> cycles k+1..k+8 give `x` = 1,0,1,0,0,1,0,1 with `x_valid` = 1. `sof` is high only at k+1 and `eof` only at k+8. At k+9: IDLE, `x` = 1.
- Back-to-back: `din_valid` held with 8'hF0 then 8'h0F -> 16 contiguous valid bits 11110000_00001111, one `sof` at bit 0 and bit 8. `din_ready` = 0 while the second word sits in `hold`.
- GAP = 2: two queued words 8'hFF, 8'h00 -> after the first `eof`, exactly 2 cycles of `x_valid` = 0 with `x` = 1, then `sof` of 8'h00.
- LSB first, MSB_FIRST 0: 8'h01 -> `x` = 1 then seven 0s. 8'h80 -> seven 0s then 1 with `eof`.
- Reset mid-operation: `clr` pulsed during bit 4 of 8'hA5 with 8'h3C held -> next cycle `x_valid` = 0, `hold_full` = 0, `busy` = 0, no `eof`. A new word 8'h81 then serialises cleanly 1,0,0,0,0,0,0,1.
